// File: rtl/mm_pkg.sv
// Shared types and defaults for the matrix-multiply job scheduler.
// Holds the FSM state enumeration, precision/gap defaults and a helper.
package mm_pkg;

  localparam int MM_MAX_PREC = 8;
  localparam int MM_GAP_CYC  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_ACT,
    S_LOAD_W,
    S_GAP,
    S_RUN,
    S_WAIT_DONE,
    S_RESULT
  } mm_state_e;

  function automatic logic prec_ok(
    input logic [3:0] p,
    input int         max_p
  );
    return (p != 4'd0) && (32'(p) <= 32'(max_p));
  endfunction

endpackage

// File: rtl/mm_sched_cnt.sv
// Loadable down-counter with terminal flag, shared by load/gap/run phases.
// Ports: clk, rst (sync, active-high), load_i/val_i load, tc_o when zero.
module mm_sched_cnt
  import mm_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Saturates at zero so an idle counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mm_sched.sv
// Job scheduler for a bit-serial matrix-multiply array: loads activations,
// then weight bits, waits a gap, strobes the run and hands off results.
// Ports: clk/rst (sync, active-high); start/precision/exp_set job request;
// busy/err status; act_rd_* and w_rd_* buffer reads; wr_en_act/act_din and
// wr_en_w/w_din FIFO writes; active/precision_o/exp_set_o to the array;
// mm_done in; result_valid/result_ack handshake.
// Optional: MM_SCHED_WATCHDOG_EN adds a 16-bit WAIT_DONE watchdog.
module mm_sched
  import mm_pkg::*;
#(
  parameter int N         = 2,
  parameter int K         = 2,
  parameter int ACT_WIDTH = 16,
  parameter int MAX_PREC  = MM_MAX_PREC,
  parameter int GAP_CYC   = MM_GAP_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [3:0]                    precision,
  input  logic [4:0]                    exp_set,
  output logic                          busy,
  output logic                          err,
  output logic                          act_rd_en,
  output logic [$clog2(K)-1:0]          act_rd_addr,
  input  logic [N*ACT_WIDTH-1:0]        act_rd_data,
  output logic                          w_rd_en,
  output logic [$clog2(K*MAX_PREC)-1:0] w_rd_addr,
  input  logic [N-1:0]                  w_rd_data,
  output logic                          wr_en_act,
  output logic [N*ACT_WIDTH-1:0]        act_din,
  output logic                          wr_en_w,
  output logic [N-1:0]                  w_din,
  output logic                          active,
  output logic [3:0]                    precision_o,
  output logic [4:0]                    exp_set_o,
  input  logic                          mm_done,
  output logic                          result_valid,
  input  logic                          result_ack
);

  localparam int AAW  = $clog2(K);
  localparam int WAW  = $clog2(K * MAX_PREC);
  localparam int CMAX = (K * MAX_PREC > GAP_CYC) ? K * MAX_PREC : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  mm_state_e      state_q;
  logic           busy_q;
  logic           err_q;
  logic           act_rd_en_q;
  logic [AAW-1:0] act_addr_q;
  logic           w_rd_en_q;
  logic [WAW-1:0] w_addr_q;
  logic           wr_act_q;
  logic           wr_w_q;
  logic           active_q;
  logic [3:0]     prec_q;
  logic [4:0]     exp_q;
  logic           rv_q;

`ifdef MM_SCHED_WATCHDOG_EN
  logic [15:0]    wd_q;
`endif

  logic           start_ok;
  logic           cnt_ld;
  logic [CW-1:0]  cnt_val;
  logic [CW-1:0]  kp_m1;
  logic           cnt_tc;

  assign start_ok = start && prec_ok(precision, MAX_PREC);
  assign kp_m1    = CW'(K * 32'(prec_q) - 1);

  // Each phase loads its length minus one on the edge that enters it.
  always_comb begin
    cnt_ld  = 1'b0;
    cnt_val = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          cnt_ld  = 1'b1;
          cnt_val = CW'(K - 1);
        end
      end
      S_LOAD_ACT: begin
        if (cnt_tc) begin
          cnt_ld  = 1'b1;
          cnt_val = kp_m1;
        end
      end
      S_LOAD_W: begin
        // GAP also spans the cycle of the trailing weight write.
        if (cnt_tc) begin
          cnt_ld  = 1'b1;
          cnt_val = CW'(GAP_CYC);
        end
      end
      S_GAP: begin
        if (cnt_tc) begin
          cnt_ld  = 1'b1;
          cnt_val = kp_m1;
        end
      end
      default: begin
        cnt_ld  = 1'b0;
      end
    endcase
  end

  mm_sched_cnt #(
    .W (CW)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_ld),
    .val_i  (cnt_val),
    .tc_o   (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      act_rd_en_q <= 1'b0;
      act_addr_q  <= '0;
      w_rd_en_q   <= 1'b0;
      w_addr_q    <= '0;
      wr_act_q    <= 1'b0;
      wr_w_q      <= 1'b0;
      active_q    <= 1'b0;
      prec_q      <= '0;
      exp_q       <= '0;
      rv_q        <= 1'b0;
`ifdef MM_SCHED_WATCHDOG_EN
      wd_q        <= '0;
`endif
    end else begin
      err_q    <= 1'b0;
      // FIFO writes trail the buffer reads by the buffer latency.
      wr_act_q <= act_rd_en_q;
      wr_w_q   <= w_rd_en_q;
      unique case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q     <= S_LOAD_ACT;
            busy_q      <= 1'b1;
            prec_q      <= precision;
            exp_q       <= exp_set;
            act_rd_en_q <= 1'b1;
            act_addr_q  <= '0;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        S_LOAD_ACT: begin
          if (cnt_tc) begin
            state_q     <= S_LOAD_W;
            act_rd_en_q <= 1'b0;
            act_addr_q  <= '0;
            w_rd_en_q   <= 1'b1;
            w_addr_q    <= '0;
          end else begin
            act_addr_q <= act_addr_q + AAW'(1);
          end
        end
        S_LOAD_W: begin
          if (cnt_tc) begin
            state_q   <= S_GAP;
            w_rd_en_q <= 1'b0;
            w_addr_q  <= '0;
          end else begin
            w_addr_q <= w_addr_q + WAW'(1);
          end
        end
        S_GAP: begin
          if (cnt_tc) begin
            state_q  <= S_RUN;
            active_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (cnt_tc) begin
            state_q  <= S_WAIT_DONE;
            active_q <= 1'b0;
`ifdef MM_SCHED_WATCHDOG_EN
            // Value equals WAIT_DONE cycles elapsed, current one included.
            wd_q     <= 16'd1;
`endif
          end
        end
        S_WAIT_DONE: begin
          if (mm_done) begin
            state_q <= S_RESULT;
            rv_q    <= 1'b1;
          end
`ifdef MM_SCHED_WATCHDOG_EN
          else if (wd_q == 16'hFFFF) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
`endif
        end
        S_RESULT: begin
          if (result_ack) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign err          = err_q;
  assign act_rd_en    = act_rd_en_q;
  assign act_rd_addr  = act_addr_q;
  assign w_rd_en      = w_rd_en_q;
  assign w_rd_addr    = w_addr_q;
  assign wr_en_act    = wr_act_q;
  assign wr_en_w      = wr_w_q;
  assign act_din      = wr_act_q ? act_rd_data : '0;
  assign w_din        = wr_w_q ? w_rd_data : '0;
  assign active       = active_q;
  assign precision_o  = prec_q;
  assign exp_set_o    = exp_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_mm_sched.sv
// Randomized scoreboard bench for mm_sched with a timeline reference model.
// Driver queues per-cycle expectations; a negedge monitor checks them.
module tb_mm_sched;

  localparam int N    = 2;
  localparam int K    = 2;
  localparam int AWD  = 16;
  localparam int MAXP = 8;
  localparam int G    = 2;
  localparam int DW   = N * AWD;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [3:0]              precision = '0;
  logic [4:0]              exp_set = '0;
  logic                    busy;
  logic                    err;
  logic                    act_rd_en;
  logic [$clog2(K)-1:0]    act_rd_addr;
  logic [DW-1:0]           act_rd_data = '0;
  logic                    w_rd_en;
  logic [$clog2(K*MAXP)-1:0] w_rd_addr;
  logic [N-1:0]            w_rd_data = '0;
  logic                    wr_en_act;
  logic [DW-1:0]           act_din;
  logic                    wr_en_w;
  logic [N-1:0]            w_din;
  logic                    active;
  logic [3:0]              precision_o;
  logic [4:0]              exp_set_o;
  logic                    mm_done = 1'b0;
  logic                    result_valid;
  logic                    result_ack = 1'b0;

  always #5 clk = ~clk;

  mm_sched #(
    .N (N), .K (K), .ACT_WIDTH (AWD), .MAX_PREC (MAXP), .GAP_CYC (G)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .precision    (precision),
    .exp_set      (exp_set),
    .busy         (busy),
    .err          (err),
    .act_rd_en    (act_rd_en),
    .act_rd_addr  (act_rd_addr),
    .act_rd_data  (act_rd_data),
    .w_rd_en      (w_rd_en),
    .w_rd_addr    (w_rd_addr),
    .w_rd_data    (w_rd_data),
    .wr_en_act    (wr_en_act),
    .act_din      (act_din),
    .wr_en_w      (wr_en_w),
    .w_din        (w_din),
    .active       (active),
    .precision_o  (precision_o),
    .exp_set_o    (exp_set_o),
    .mm_done      (mm_done),
    .result_valid (result_valid),
    .result_ack   (result_ack)
  );

  typedef struct {
    int are; int aad; int wre; int wad;
    int wa; logic [31:0] adin; int ww; int wdin;
    int act; int busy; int err; int rv;
    int prec; int exps;
  } exp_t;

  exp_t q[$];
  exp_t mx;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cur_prec = 0;
  int cur_exp = 0;
  logic [DW-1:0] amem[K];
  logic [N-1:0]  wmem[K*MAXP];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (q.size() > 0) begin
      mx = q.pop_front();
      chk("act_rd_en", 32'(act_rd_en), mx.are);
      chk("act_rd_addr", 32'(act_rd_addr), mx.aad);
      chk("w_rd_en", 32'(w_rd_en), mx.wre);
      chk("w_rd_addr", 32'(w_rd_addr), mx.wad);
      chk("wr_en_act", 32'(wr_en_act), mx.wa);
      chk("act_din", 32'(act_din), mx.adin);
      chk("wr_en_w", 32'(wr_en_w), mx.ww);
      chk("w_din", 32'(w_din), mx.wdin);
      chk("active", 32'(active), mx.act);
      chk("busy", 32'(busy), mx.busy);
      chk("err", 32'(err), mx.err);
      chk("result_valid", 32'(result_valid), mx.rv);
      chk("precision_o", 32'(precision_o), mx.prec);
      chk("exp_set_o", 32'(exp_set_o), mx.exps);
    end
  end

  function automatic exp_t idle_exp();
    exp_t x;
    x = '{default: 0};
    x.prec = cur_prec;
    x.exps = cur_exp;
    return x;
  endfunction

  task automatic reset_phase();
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      rst = (t < 2);
      start = 1'b0;
      mm_done = 1'b0;
      result_ack = 1'b0;
      cur_prec = 0;
      cur_exp = 0;
      if (t > 0) q.push_back(idle_exp());
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      precision = 4'($urandom);
      mm_done = 1'b0;
      result_ack = 1'b0;
      q.push_back(idle_exp());
    end
  endtask

  // Timeline model: start at t=0, K activation reads from t=1, K*p weight
  // reads right after, writes one cycle behind, G idle cycles after the last
  // weight write, K*p active cycles, then mm_done after d, ack after a.
  task automatic run_job(input int p, input int d, input int a,
                         input bit hold, input bit do_rst);
    int kp, rs, af, md, ak, len, e, rst_at;
    bit legal, live;
    exp_t x;
    legal = (p >= 1) && (p <= MAXP);
    kp = K * p;
    rs = K + kp + 2 + G;
    af = rs + kp;
    md = af + d;
    ak = md + 1 + a;
    e = $urandom_range(0, 31);
    rst_at = (legal && do_rst) ? rs + $urandom_range(0, kp - 1) : 0;
    for (int i = 0; i < K; i++) amem[i] = DW'($urandom);
    for (int i = 0; i < K * MAXP; i++) wmem[i] = N'($urandom);
    len = !legal ? 2 : ((rst_at > 0) ? rst_at + 2 : ak + 2);
    for (int t = 0; t < len; t++) begin
      @(posedge clk); #1;
      rst = (rst_at > 0) && (t == rst_at);
      start = (t == 0) || (hold && legal && rst_at == 0 && t <= ak);
      precision = (t == 0) ? 4'(p) : 4'($urandom);
      exp_set = (t == 0) ? 5'(e) : 5'($urandom);
      act_rd_data = (legal && t >= 2 && t <= K + 1) ?
                    amem[t-2] : DW'($urandom);
      w_rd_data = (legal && t >= K + 2 && t <= K + kp + 1) ?
                  wmem[t-K-2] : N'($urandom);
      mm_done = (legal && rst_at == 0 && t == md) ||
                (legal && t < af && $urandom_range(0, 3) == 0);
      result_ack = legal && (rst_at == 0) && (t == ak);
      live = legal;
      if (legal && t == 1) begin
        cur_prec = p;
        cur_exp = e;
      end
      if (rst_at > 0 && t == rst_at + 1) begin
        cur_prec = 0;
        cur_exp = 0;
        live = 1'b0;
      end
      x = idle_exp();
      x.are = int'(live && t >= 1 && t <= K);
      x.aad = (x.are != 0) ? t - 1 : 0;
      x.wa = int'(live && t >= 2 && t <= K + 1);
      x.adin = (x.wa != 0) ? 32'(amem[t-2]) : 32'd0;
      x.wre = int'(live && t >= K + 1 && t <= K + kp);
      x.wad = (x.wre != 0) ? t - K - 1 : 0;
      x.ww = int'(live && t >= K + 2 && t <= K + kp + 1);
      x.wdin = (x.ww != 0) ? int'(wmem[t-K-2]) : 0;
      x.act = int'(live && t >= rs && t < af);
      x.rv = int'(live && t >= md + 1 && t <= ak);
      x.busy = int'(live && t >= 1 && t <= ak);
      x.err = int'(!legal && t == 1);
      q.push_back(x);
    end
  endtask

  initial begin
    reset_phase();
    run_job(4, 5, 3, 1'b0, 1'b0);
    run_job(0, 0, 0, 1'b0, 1'b0);
    run_job(9, 0, 0, 1'b0, 1'b0);
    run_job(15, 0, 0, 1'b0, 1'b0);
    run_job(3, 2, 1, 1'b0, 1'b1);
    run_job(5, 1, 2, 1'b0, 1'b0);
    run_job(2, 3, 2, 1'b1, 1'b0);
    run_job(8, 0, 0, 1'b0, 1'b0);
    run_job(1, 6, 4, 1'b0, 1'b0);
    idle_cycles(2);
    for (int j = 0; j < 30; j++) begin
      run_job($urandom_range(0, 10), $urandom_range(0, 6),
              $urandom_range(0, 4), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0));
    end
    idle_cycles(3);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
